ifu_fetch_stage: RTL and testbench
==================================

Name: ifu_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Owns the PC register, a single-outstanding instruction-memory request port, a static branch predictor, a 1-entry skid buffer and the IF/ID output register.
- Feeds decode with inst/pc/bpu_jump/if_valid.
- Accepts decode's redirect (jump_ena/jump_pc) and flushes wrong-path fetches.

Parameters:
- RESET_PC, 32'h8000_0000, PC fetched first after reset.
- XLEN, 32, data/address width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-low
- imem_req_o  out  1  fetch request valid
- imem_addr_o  out  32  fetch address (word aligned)
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  response valid (≥1 cycle after gnt)
- imem_rdata_i  in  32  instruction word
- inst_o  out  32  IF/ID instruction
- pc_o  out  32  IF/ID pc
- bpu_jump_o  out  1  predicted-taken flag for the branch in IF/ID
- if_valid_o  out  1  IF/ID holds a valid instruction
- id_ready_i  in  1  decode can accept (ex_ready)
- id_stall_i  in  1  decode load/CSR hazard stall (id_ex_flush)
- redirect_i  in  1  decode jump_ena
- redirect_pc_i  in  32  decode jump_pc

Behaviour:
- Reset (rst=0 at edge):
  - pc_r=RESET_PC; state=IDLE; imem_req_o=0.
  - if_valid_o=0, inst_o=0, pc_o=0, bpu_jump_o=0; skid and drop cleared.
  - Reset mid-transaction abandons the outstanding request; a late rvalid after reset is ignored because state is IDLE.
- consume = if_valid_o & id_ready_i & ~id_stall_i.
- Redirect is honoured only when redirect_i & consume; otherwise redirect_i is ignored.
- FSM states:
  - IDLE: always goes to REQ the next cycle.
  - REQ: imem_req_o=1, imem_addr_o=pc_r; on gnt go to WAIT.
  - WAIT: wait for rvalid; on rvalid go to REQ if skid will be empty, else HOLD.
  - HOLD: wait until skid drains, then go to REQ.
- At most one request outstanding. A new request is issued the cycle after the response is captured, never earlier.
- Response capture (rvalid in WAIT, drop=0):
  - Target is IF/ID if it is empty or consumed this cycle, else the skid.
  - The entry stores {inst, pc_r, pred}.
  - pc_r <= pred_taken ? target : pc_r+4, all arithmetic mod 2^32.
- Prediction:
  - JAL (opcode 1101111): pc_r <= pc+J-imm (sign-extended); bpu_jump=0, because decode does not resolve JAL.
  - B-type (1100011) with inst[31]=1 (backward): taken, pc_r <= pc+B-imm, bpu_jump=1.
  - All else: not taken, bpu_jump=0.
- IF/ID register:
  - Holds its value while if_valid_o & ~consume.
  - On consume, loads the skid entry if the skid is valid, else the captured response, else goes invalid.
  - Skid full and IF/ID full together must not coincide with a new rvalid; this is guaranteed by the FSM.
- Redirect handling:
  - Clears the IF/ID register and the skid the same edge, so if_valid_o=0 next cycle.
  - Sets pc_r <= redirect_pc_i.
  - If state=WAIT, or REQ with gnt this cycle: drop <= 1 and state WAIT. The next rvalid is discarded (drop cleared), then the FSM goes to REQ with the redirect pc.
  - If REQ without gnt: imem_addr_o switches to the redirect pc next cycle with req held high (permitted by the imem protocol).
  - If IDLE/HOLD: go to REQ.
- Simultaneous redirect and rvalid in the same cycle: the response is discarded, pc_r = redirect_pc_i, state goes to REQ.
- Outputs are registered (except imem_req_o/imem_addr_o, which are decoded from state/pc_r). Zero-latency paths from decode inputs to imem are forbidden.

Optional Feature:
- Macro: YSYX_25060170_IFU_STATIC_BPU_EN.
- Defined: backward-branch predict-taken as above.
- Undefined: all branches are predicted not taken and bpu_jump_o is constantly 0. JAL redirection is kept (not a prediction).

Test Plan:
- Reset release, imem gnt same cycle, rvalid next cycle with 32'h00000013 -> request at 0x80000000, then if_valid_o=1, pc_o=0x80000000, next request addr 0x80000004.
- Backward branch 32'hFE000EE3 (beq x0,x0,-4) at 0x80000010 -> bpu_jump_o=1, next imem_addr_o=0x8000000C; with macro undefined -> bpu_jump_o=0, addr 0x80000014.
- JAL 32'h0100006F at 0x80000020 -> bpu_jump_o=0, next fetch 0x80000030.
- id_ready_i=0 for 5 cycles with IF/ID full and a response arriving -> response held in skid, no further imem_req_o, inst_o stable; on ready, skid drains in order, no loss or duplication.
- Redirect to 0x80000100 while a request is in WAIT, rvalid 2 cycles later with 32'hDEADBEEF -> data dropped, if_valid_o=0, next request addr 0x80000100.
- rst=0 asserted while in WAIT, then rvalid -> all outputs 0, first request after release is RESET_PC.

Source files
------------

// File: rtl/ifu_fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem port, static predictor, skid buffer and IF/ID register.
// Define YSYX_25060170_IFU_STATIC_BPU_EN to predict backward conditional branches taken.
module ifu_fetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] pc_o,
  output logic            bpu_jump_o,
  output logic            if_valid_o,
  input  logic            id_ready_i,
  input  logic            id_stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t          r_state, w_state_nxt;
  logic            r_drop, w_drop_nxt;
  logic [XLEN-1:0] r_pc;

  logic            r_if_valid, r_bpu;
  logic [31:0]     r_inst;
  logic [XLEN-1:0] r_if_pc;
  logic            r_sk_valid, r_sk_bpu;
  logic [31:0]     r_sk_inst;
  logic [XLEN-1:0] r_sk_pc;

  logic            w_consume, w_redirect, w_capture, w_ifid_free;
  logic            w_is_jal, w_pred_br, w_pred_taken;
  logic [XLEN-1:0] w_imm_j, w_target, w_pc_seq;

  assign w_consume   = r_if_valid & id_ready_i & ~id_stall_i;
  assign w_redirect  = redirect_i & w_consume;
  assign w_ifid_free = ~r_if_valid | w_consume;
  // A response is discarded if it belongs to a flushed request or collides with a redirect.
  assign w_capture   = (r_state == S_WAIT) & imem_rvalid_i & ~r_drop & ~w_redirect;

  assign w_is_jal = (imem_rdata_i[6:0] == OP_JAL);
  assign w_imm_j  = {{(XLEN-20){imem_rdata_i[31]}}, imem_rdata_i[19:12], imem_rdata_i[20],
                     imem_rdata_i[30:21], 1'b0};
  assign w_pc_seq = r_pc + XLEN'(4);

`ifdef YSYX_25060170_IFU_STATIC_BPU_EN
  logic [XLEN-1:0] w_imm_b;
  assign w_imm_b   = {{(XLEN-12){imem_rdata_i[31]}}, imem_rdata_i[7], imem_rdata_i[30:25],
                      imem_rdata_i[11:8], 1'b0};
  assign w_pred_br = (imem_rdata_i[6:0] == OP_BRANCH) & imem_rdata_i[31];
  assign w_target  = r_pc + (w_is_jal ? w_imm_j : w_imm_b);
`else
  assign w_pred_br = 1'b0;
  assign w_target  = r_pc + w_imm_j;
`endif

  assign w_pred_taken = w_is_jal | w_pred_br;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_drop_nxt  = r_drop;
    unique case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        if (imem_gnt_i) begin
          w_state_nxt = S_WAIT;
          w_drop_nxt  = w_redirect;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          w_drop_nxt  = 1'b0;
          w_state_nxt = (w_capture & ~w_ifid_free) ? S_HOLD : S_REQ;
        end else if (w_redirect) begin
          w_drop_nxt  = 1'b1;
        end
      end
      S_HOLD: if (~r_sk_valid | w_consume) w_state_nxt = S_REQ;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_drop  <= 1'b0;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_drop  <= w_drop_nxt;
      if (w_redirect)     r_pc <= redirect_pc_i;
      else if (w_capture) r_pc <= w_pred_taken ? w_target : w_pc_seq;
    end
  end

  // Skid only fills while IF/ID is occupied, so a valid skid always implies a valid IF/ID.
  always_ff @(posedge clk) begin
    if (!rst || w_redirect) begin
      r_if_valid <= 1'b0;
      r_inst     <= '0;
      r_if_pc    <= '0;
      r_bpu      <= 1'b0;
      r_sk_valid <= 1'b0;
      r_sk_inst  <= '0;
      r_sk_pc    <= '0;
      r_sk_bpu   <= 1'b0;
    end else if (w_ifid_free) begin
      if (r_sk_valid) begin
        r_if_valid <= 1'b1;
        r_inst     <= r_sk_inst;
        r_if_pc    <= r_sk_pc;
        r_bpu      <= r_sk_bpu;
        r_sk_valid <= w_capture;
        if (w_capture) begin
          r_sk_inst <= imem_rdata_i;
          r_sk_pc   <= r_pc;
          r_sk_bpu  <= w_pred_br;
        end
      end else begin
        r_if_valid <= w_capture;
        if (w_capture) begin
          r_inst  <= imem_rdata_i;
          r_if_pc <= r_pc;
          r_bpu   <= w_pred_br;
        end
      end
    end else if (w_capture) begin
      r_sk_valid <= 1'b1;
      r_sk_inst  <= imem_rdata_i;
      r_sk_pc    <= r_pc;
      r_sk_bpu   <= w_pred_br;
    end
  end

  assign imem_req_o  = (r_state == S_REQ);
  assign imem_addr_o = r_pc;
  assign inst_o      = r_inst;
  assign pc_o        = r_if_pc;
  assign bpu_jump_o  = r_bpu;
  assign if_valid_o  = r_if_valid;

endmodule

// File: tb/tb_ifu_fetch_stage.sv
// Self-checking bench for ifu_fetch_stage: directed scenarios, then randomized imem/decode traffic
// compared against an instruction-stream model built from generated program contents.
module tb_ifu_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
`ifdef YSYX_25060170_IFU_STATIC_BPU_EN
  localparam bit BPU_EN = 1'b1;
`else
  localparam bit BPU_EN = 1'b0;
`endif

  localparam int K_ALU = 0, K_FWD = 1, K_BWD = 2, K_JAL = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_addr_o, imem_rdata_i;
  logic [31:0] inst_o, pc_o, redirect_pc_i;
  logic        bpu_jump_o, if_valid_o, id_ready_i, id_stall_i, redirect_i;

  ifu_fetch_stage #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .inst_o(inst_o), .pc_o(pc_o), .bpu_jump_o(bpu_jump_o), .if_valid_o(if_valid_o),
    .id_ready_i(id_ready_i), .id_stall_i(id_stall_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Program image generated on demand; the model uses the recorded kind/offset, not a decoder.
  logic [31:0] mem_inst [logic [31:0]];
  int          mem_kind [logic [31:0]];
  int          mem_off  [logic [31:0]];

  function automatic logic [31:0] encode_b(input int off, input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [2:0] f3);
    logic [12:0] im;
    im = off[12:0];
    return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] encode_j(input int off, input logic [4:0] rd);
    logic [20:0] im;
    im = off[20:0];
    return {im[20], im[10:1], im[11], im[19:12], rd, 7'b1101111};
  endfunction

  function automatic void gen(input logic [31:0] a);
    int          k, off;
    logic [31:0] r;
    if (mem_inst.exists(a)) return;
    r = $urandom();
    k = $urandom_range(0, 9);
    if (k <= 5) begin
      mem_kind[a] = K_ALU; off = 4;
      mem_inst[a] = {r[31:7], 7'b0010011};
    end else if (k == 6) begin
      mem_kind[a] = K_FWD; off = 4 * $urandom_range(1, 16);
      mem_inst[a] = encode_b(off, r[4:0], r[9:5], r[12:10]);
    end else if (k <= 8) begin
      mem_kind[a] = K_BWD; off = -4 * $urandom_range(1, 8);
      mem_inst[a] = encode_b(off, r[4:0], r[9:5], r[12:10]);
    end else begin
      mem_kind[a] = K_JAL; off = 4 * ($urandom_range(0, 32) - 16);
      mem_inst[a] = encode_j(off, r[4:0]);
    end
    mem_off[a] = off;
  endfunction

  function automatic logic [31:0] inst_at(input logic [31:0] a);
    gen(a);
    return mem_inst[a];
  endfunction

  function automatic logic [31:0] next_pc(input int kind, input logic [31:0] a, input int off);
    if (kind == K_JAL) return a + 32'(off);
    if (kind == K_BWD && BPU_EN) return a + 32'(off);
    return a + 32'd4;
  endfunction

  // Fetch one word: wait for a request, grant it, answer next cycle. Returns on the negedge after capture.
  task automatic fetch(input string name, input logic [31:0] data, input logic [31:0] exp_addr);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = imem_req_o;
    end
    check({name, "_req_seen"}, {31'd0, seen}, 32'd1);
    check({name, "_req_addr"}, imem_addr_o, exp_addr);
    imem_gnt_i = 1'b1;
    @(negedge clk);
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = data;
    @(negedge clk);
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
  endtask

  // Random-phase state
  logic [31:0] model_pc;
  bit          pend;
  int          lat;
  logic [31:0] paddr;
  int          delivered;

  task automatic rand_cycle();
    bit          consume;
    int          kind;
    logic [31:0] rpc;
    @(negedge clk);
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    if (pend) begin
      if (imem_req_o) check("one_outstanding", {31'd0, imem_req_o}, 32'd0);
      if (lat == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = inst_at(paddr);
        pend          = 1'b0;
      end else lat--;
    end else if (imem_req_o) begin
      if (imem_addr_o[1:0] != 2'b00) check("addr_aligned", {30'd0, imem_addr_o[1:0]}, 32'd0);
      if ($urandom_range(0, 2) != 0) begin
        imem_gnt_i = 1'b1;
        pend       = 1'b1;
        paddr      = imem_addr_o;
        lat        = $urandom_range(0, 3);
      end
    end
    id_ready_i = ($urandom_range(0, 3) != 0);
    id_stall_i = ($urandom_range(0, 5) == 0);
    redirect_i = 1'b0;
    consume    = if_valid_o & id_ready_i & ~id_stall_i;
    rpc        = RESET_PC + 32'(4 * $urandom_range(0, 1023));
    if (consume) begin
      gen(model_pc);
      kind = mem_kind[model_pc];
      check("stream_pc", pc_o, model_pc);
      check("stream_inst", inst_o, mem_inst[model_pc]);
      check("stream_bpu", {31'd0, bpu_jump_o}, {31'd0, (kind == K_BWD) && BPU_EN});
      delivered++;
      if ($urandom_range(0, 11) == 0) begin
        redirect_i    = 1'b1;
        redirect_pc_i = rpc;
        model_pc      = rpc;
      end else begin
        model_pc = next_pc(kind, model_pc, mem_off[model_pc]);
      end
    end else if ($urandom_range(0, 7) == 0) begin
      redirect_i    = 1'b1;
      redirect_pc_i = rpc;
    end
  endtask

  initial begin
    rst = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    id_ready_i = 1'b0; id_stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;

    check("pin_enc_beq", encode_b(-4, 5'd0, 5'd0, 3'd0), 32'hFE00_0EE3);
    check("pin_enc_jal", encode_j(16, 5'd0), 32'h0100_006F);
    check("pin_next_jal", next_pc(K_JAL, 32'h8000_0020, 16), 32'h8000_0030);
    check("pin_next_bwd", next_pc(K_BWD, 32'h8000_0010, -4), BPU_EN ? 32'h8000_000C : 32'h8000_0014);

    // Reset state and first fetch
    repeat (3) @(negedge clk);
    check("rst_req", {31'd0, imem_req_o}, 32'd0);
    check("rst_valid", {31'd0, if_valid_o}, 32'd0);
    check("rst_inst", inst_o, 32'd0);
    check("rst_pc", pc_o, 32'd0);
    check("rst_bpu", {31'd0, bpu_jump_o}, 32'd0);
    rst = 1'b1;
    fetch("first", 32'h0000_0013, 32'h8000_0000);
    check("first_valid", {31'd0, if_valid_o}, 32'd1);
    check("first_pc", pc_o, 32'h8000_0000);
    check("first_inst", inst_o, 32'h0000_0013);
    check("first_next_addr", imem_addr_o, 32'h8000_0004);

    // Backward branch
    id_ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h8000_0010;
    @(negedge clk);
    id_ready_i = 1'b0; redirect_i = 1'b0;
    check("redir_req_valid", {31'd0, if_valid_o}, 32'd0);
    fetch("beq", 32'hFE00_0EE3, 32'h8000_0010);
    check("beq_pc", pc_o, 32'h8000_0010);
    check("beq_bpu", {31'd0, bpu_jump_o}, {31'd0, BPU_EN});
    check("beq_next_addr", imem_addr_o, BPU_EN ? 32'h8000_000C : 32'h8000_0014);

    // JAL
    id_ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h8000_0020;
    @(negedge clk);
    id_ready_i = 1'b0; redirect_i = 1'b0;
    fetch("jal", 32'h0100_006F, 32'h8000_0020);
    check("jal_pc", pc_o, 32'h8000_0020);
    check("jal_bpu", {31'd0, bpu_jump_o}, 32'd0);
    check("jal_next_addr", imem_addr_o, 32'h8000_0030);

    // Skid: IF/ID full, decode stalled, response parks in the skid
    fetch("skid", 32'h0010_0093, 32'h8000_0030);
    for (int i = 0; i < 5; i++) begin
      check("skid_no_req", {31'd0, imem_req_o}, 32'd0);
      check("skid_inst_stable", inst_o, 32'h0100_006F);
      @(negedge clk);
    end
    id_ready_i = 1'b1;
    @(negedge clk);
    check("skid_drain_inst", inst_o, 32'h0010_0093);
    check("skid_drain_pc", pc_o, 32'h8000_0030);
    check("skid_drain_req", {31'd0, imem_req_o}, 32'd1);
    check("skid_drain_addr", imem_addr_o, 32'h8000_0034);
    @(negedge clk);
    check("skid_no_dup", {31'd0, if_valid_o}, 32'd0);
    id_ready_i = 1'b0;

    // Redirect while WAIT, late response dropped
    fetch("pre_wait", 32'h0000_0013, 32'h8000_0034);
    imem_gnt_i = 1'b1;
    @(negedge clk);
    imem_gnt_i = 1'b0; id_ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h8000_0100;
    @(negedge clk);
    id_ready_i = 1'b0; redirect_i = 1'b0;
    check("drop_valid0", {31'd0, if_valid_o}, 32'd0);
    check("drop_no_req", {31'd0, imem_req_o}, 32'd0);
    @(negedge clk);
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid_i = 1'b0;
    check("drop_valid1", {31'd0, if_valid_o}, 32'd0);
    check("drop_req", {31'd0, imem_req_o}, 32'd1);
    check("drop_addr", imem_addr_o, 32'h8000_0100);

    // Reset while WAIT, late response ignored
    imem_gnt_i = 1'b1;
    @(negedge clk);
    imem_gnt_i = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("rstw_req", {31'd0, imem_req_o}, 32'd0);
    check("rstw_valid", {31'd0, if_valid_o}, 32'd0);
    rst = 1'b1; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid_i = 1'b0;
    check("rstw_valid_after", {31'd0, if_valid_o}, 32'd0);
    check("rstw_inst", inst_o, 32'd0);
    check("rstw_pc", pc_o, 32'd0);
    check("rstw_req_after", {31'd0, imem_req_o}, 32'd1);
    check("rstw_addr", imem_addr_o, RESET_PC);

    // Randomized traffic against the stream model
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    pend = 1'b0; lat = 0; paddr = 32'h0; delivered = 0; model_pc = RESET_PC;
    for (int c = 0; c < 4000; c++) rand_cycle();
    check("progress", {31'd0, delivered > 200}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
